wired_pkg_queue: RTL and testbench
==================================

// Module: wired_pkg_queue
// PURPOSE
// Front-end instruction-package queue: the producer end of the backend's pkg_valid/pkg_ready/pkg_mask/pkg interface.
// Buffers decoded 2-wide pipeline_ctrl_pack_t packets from decode and presents them in order to the backend rename stage.
// On a backend redirect, it empties itself and discards in-flight wrong-path packets by thread-id (tid) tag.
// PARAMETERS
// DEPTH  4  packet entries in the queue; a power of two, >= 2
// PORTS
// clk             in   1       clock
// rst             in   1       async reset, active-high
// redirect_i      in   1       bpu_correct.redirect from backend
// redirect_tid_i  in   1       bpu_correct.tid: the tid of the new path
// in_valid_i      in   1       decode offers a packet
// in_ready_o      out  1       queue accepts the offered packet
// in_mask_i       in   2       per-slot valid of the offered packet
// in_pkg_i        in   2xpipeline_ctrl_pack_t  offered packet
// pkg_valid_o     out  1       head packet valid toward backend
// pkg_ready_i     in   1       backend accepts the head packet
// pkg_mask_o      out  2       per-slot valid of the head packet
// pkg_o           out  2xpipeline_ctrl_pack_t  head packet
// count_o         out  $clog2(DEPTH)+1  occupied entries
// drop_cnt_o      out  16      saturating count of discarded stale packets
// BEHAVIOUR
// - Reset, async while rst=1:
//   - head, tail, count, drop_cnt and cur_tid_q clear to 0.
//   - pkg_valid_o=0, pkg_mask_o=0, in_ready_o=0.
// - Reset release: in_ready_o=1 in the first cycle after release.
// - Storage is a circular buffer; head and tail pointers are $clog2(DEPTH) bits and wrap naturally.
// - Status signals:
//   - full = (count==DEPTH).
//   - in_ready_o = !full; there is no pop-bypass into a full queue.
// - Push: the offered packet is taken when in_valid_i && in_ready_o && !redirect_i.
//   - Stale: in_pkg_i[0].bpu_predict.tid != cur_tid_q.
//     - The packet is consumed but not written; drop_cnt increments and saturates at 16'hFFFF.
//   - Empty mask: in_mask_i==2'b00. The packet is consumed but not written; drop_cnt is unchanged.
//   - Otherwise the packet and its mask are written at tail; tail++ and count++.
// - Output:
//   - pkg_valid_o = (count!=0); pkg_o and pkg_mask_o are read from the head entry.
//   - pkg_mask_o = 0 when the queue is empty.
//   - Latency: a packet pushed in cycle N is visible at the output in cycle N+1 at the earliest. There is no flow-through.
//   - pkg_o and pkg_mask_o are stable while pkg_valid_o && !pkg_ready_i.
// - Pop: on pkg_valid_o && pkg_ready_i && !redirect_i, head++ and count--.
// - Push and pop in the same cycle: both take effect and count is unchanged.
// - Redirect (redirect_i=1) has priority over push and pop in the same cycle:
//   - Next cycle: head=tail=0, count=0, pkg_valid_o=0, and cur_tid_q=redirect_tid_i.
//   - Any push or pop offered in the redirect cycle is ignored and is not counted as a drop.
//   - The backend must also ignore any handshake in that cycle.
// - Back-to-back redirects: each one re-clears the queue, and the last tid wins.
// - Full with a simultaneous pop: in_ready_o stays 0 in that cycle. A push becomes possible the next cycle.
// - Redirect while full: the next cycle is empty, in_ready_o=1 and pkg_valid_o=0.
// - count_o never exceeds DEPTH. Pointer wrap keeps FIFO order for any sequence of operations.
// TESTING
// - Reset then push packets P1,P2,P3 (tid 0, mask 2'b11) with pkg_ready_i=0:
//   -> count_o=3 and pkg_o=P1 held stable.
//   -> Then set pkg_ready_i=1: P1,P2,P3 appear on consecutive cycles, after which pkg_valid_o=0.
// - Push 4 packets with DEPTH=4:
//   -> in_ready_o=0 and count_o=4.
//   -> Pop one: in_ready_o=1 the next cycle.
//   -> Then 8 more push/pop pairs wrap both pointers, and order is preserved.
// - Hold a continuous push and pop every cycle for 20 cycles:
//   -> count_o stays 1.
//   -> The output sequence equals the input sequence delayed by 1 cycle.
// - With 3 entries queued, raise redirect_i=1 with redirect_tid_i=1, plus a simultaneous push:
//   -> Next cycle count_o=0 and pkg_valid_o=0; the pushed packet is absent.
// - After redirect to tid 1, push a tid-0 packet then a tid-1 packet:
//   -> drop_cnt_o=1 and count_o=1; pkg_o carries the tid-1 packet.
//   -> A packet with mask 2'b00 is consumed and drop_cnt_o stays 1.
// - Assert rst mid-operation with count_o=2:
//   -> pkg_valid_o=0 and in_ready_o=0 immediately.
//   -> After release: count_o=0, drop_cnt_o=0 and in_ready_o=1.

Source files
------------

// File: rtl/wired_pkg_queue_if.sv
// Packet type shared by decode and the backend, plus the decode/backend handshake bundle
// seen by the instruction-package queue.
package wired_pkg_queue_pkg;

    typedef struct packed {
        logic taken;
        logic tid;
    } bpu_predict_t;

    typedef struct packed {
        logic [31:0]  pc;
        logic [31:0]  inst;
        bpu_predict_t bpu_predict;
    } pipeline_ctrl_pack_t;

endpackage

interface wired_pkg_queue_if;
    import wired_pkg_queue_pkg::*;

    logic                      in_valid_i;
    logic                      in_ready_o;
    logic [1:0]                in_mask_i;
    pipeline_ctrl_pack_t [1:0] in_pkg_i;
    logic                      pkg_valid_o;
    logic                      pkg_ready_i;
    logic [1:0]                pkg_mask_o;
    pipeline_ctrl_pack_t [1:0] pkg_o;

    modport slave (
        input  in_valid_i, in_mask_i, in_pkg_i, pkg_ready_i,
        output in_ready_o, pkg_valid_o, pkg_mask_o, pkg_o
    );

    modport master (
        output in_valid_i, in_mask_i, in_pkg_i, pkg_ready_i,
        input  in_ready_o, pkg_valid_o, pkg_mask_o, pkg_o
    );

endinterface

// File: rtl/wired_pkg_queue.sv
// In-order queue of decoded 2-wide packets toward rename; a redirect flushes it and
// switches the accepted thread-id so wrong-path packets still in flight get dropped.
module wired_pkg_queue
    import wired_pkg_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    redirect_i,
    input  logic                    redirect_tid_i,
    wired_pkg_queue_if.slave        q_if,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic [15:0]             drop_cnt_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    pipeline_ctrl_pack_t [1:0] pkg_mem [DEPTH];
    logic [1:0]                mask_mem [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [PW:0]   count_q, count_d;
    logic [15:0]   drop_q, drop_d;
    logic          cur_tid_q, cur_tid_d;
    logic          in_ready_q, in_ready_d;

    logic push_fire, pop_fire, stale, write_en, drop_en;

    assign push_fire = q_if.in_valid_i && in_ready_q && !redirect_i;
    assign pop_fire  = (count_q != '0) && q_if.pkg_ready_i && !redirect_i;
    assign stale     = (q_if.in_pkg_i[0].bpu_predict.tid != cur_tid_q);
    assign write_en  = push_fire && !stale && (q_if.in_mask_i != 2'b00);
    assign drop_en   = push_fire && stale;

    always_comb begin
        // NOTE: every variable gets its default first so no latch is inferred.
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        drop_d    = drop_q;
        cur_tid_d = cur_tid_q;
        if (redirect_i) begin
            head_d    = '0;
            tail_d    = '0;
            count_d   = '0;
            cur_tid_d = redirect_tid_i;
        end else begin
            if (write_en) tail_d = tail_q + 1'b1;
            if (pop_fire) head_d = head_q + 1'b1;
            if (write_en && !pop_fire)      count_d = count_q + 1'b1;
            else if (!write_en && pop_fire) count_d = count_q - 1'b1;
            if (drop_en && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
        end
        // Ready is registered so it stays low through reset and rises on the first edge after.
        in_ready_d = (count_d != FULL_CNT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            drop_q     <= '0;
            cur_tid_q  <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            drop_q     <= drop_d;
            cur_tid_q  <= cur_tid_d;
            in_ready_q <= in_ready_d;
        end
    end

    // NOTE: payload storage is not reset; count/mask gating keeps stale contents invisible.
    always_ff @(posedge clk) begin
        if (write_en) begin
            pkg_mem[tail_q]  <= q_if.in_pkg_i;
            mask_mem[tail_q] <= q_if.in_mask_i;
        end
    end

    assign q_if.in_ready_o  = in_ready_q;
    assign q_if.pkg_valid_o = (count_q != '0);
    assign q_if.pkg_o       = pkg_mem[head_q];
    assign q_if.pkg_mask_o  = (count_q != '0) ? mask_mem[head_q] : 2'b00;
    assign count_o          = count_q;
    assign drop_cnt_o       = drop_q;

endmodule

// File: tb/tb_wired_pkg_queue.sv
// Self-checking bench for wired_pkg_queue: directed scenarios plus random traffic,
// all checked against a queue-based reference model.
module tb_wired_pkg_queue;
    import wired_pkg_queue_pkg::*;

    localparam int DEPTH = 4;

    typedef pipeline_ctrl_pack_t [1:0] pair_t;
    typedef struct {
        pair_t      pkg;
        logic [1:0] mask;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_i = 1'b0;
    logic        redirect_tid_i = 1'b0;
    logic [2:0]  count_o;
    logic [15:0] drop_cnt_o;

    wired_pkg_queue_if q_if ();

    wired_pkg_queue #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_i     (redirect_i),
        .redirect_tid_i (redirect_tid_i),
        .q_if           (q_if),
        .count_o        (count_o),
        .drop_cnt_o     (drop_cnt_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    ent_t m_q[$];
    logic m_tid;
    int   m_drop;
    bit   m_ready;
    pair_t first_pkg;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit v, input logic [1:0] m, input logic tid, input bit rdy,
                         input bit rd = 1'b0, input logic rt = 1'b0);
        pair_t p;
        for (int s = 0; s < 2; s++) begin
            p[s].pc                = $urandom;
            p[s].inst              = $urandom;
            p[s].bpu_predict.taken = 1'($urandom_range(0, 1));
            p[s].bpu_predict.tid   = tid;
        end
        q_if.in_valid_i  = v;
        q_if.in_mask_i   = m;
        q_if.in_pkg_i    = p;
        q_if.pkg_ready_i = rdy;
        redirect_i       = rd;
        redirect_tid_i   = rt;
    endtask

    // Compare outputs mid-cycle, advance the model on the current inputs, then cross the edge.
    task automatic step();
        bit   do_pop;
        bit   do_push;
        ent_t e;
        @(negedge clk);
        check("in_ready", q_if.in_ready_o, m_ready);
        check("pkg_valid", q_if.pkg_valid_o, m_q.size() != 0);
        check("count", count_o, m_q.size());
        check("drop_cnt", drop_cnt_o, m_drop);
        check("pkg_mask", q_if.pkg_mask_o, (m_q.size() != 0) ? m_q[0].mask : 2'b00);
        if (m_q.size() != 0) check("pkg", q_if.pkg_o, m_q[0].pkg);
        if (redirect_i) begin
            m_q.delete();
            m_tid = redirect_tid_i;
        end else begin
            do_pop  = (m_q.size() != 0) && q_if.pkg_ready_i;
            do_push = q_if.in_valid_i && m_ready;
            if (do_pop) void'(m_q.pop_front());
            if (do_push) begin
                if (q_if.in_pkg_i[0].bpu_predict.tid != m_tid) begin
                    if (m_drop < 65535) m_drop++;
                end else if (q_if.in_mask_i != 2'b00) begin
                    e.pkg  = q_if.in_pkg_i;
                    e.mask = q_if.in_mask_i;
                    m_q.push_back(e);
                end
            end
        end
        m_ready = (m_q.size() < DEPTH);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_pkg_valid", q_if.pkg_valid_o, 1'b0);
        check("rst_in_ready", q_if.in_ready_o, 1'b0);
        check("rst_pkg_mask", q_if.pkg_mask_o, 2'b00);
        m_q.delete();
        m_tid   = 1'b0;
        m_drop  = 0;
        m_ready = 1'b0;
        drive(0, 2'b00, 1'b0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rel_count", count_o, 3'd0);
        check("rel_drop", drop_cnt_o, 16'd0);
        step();
        check("rel_in_ready", q_if.in_ready_o, 1'b1);
    endtask

    initial begin
        logic tid;
        drive(0, 2'b00, 1'b0, 0);
        do_reset();

        // Three packets queued with backend stalled, then drained.
        for (int i = 0; i < 3; i++) begin
            drive(1, 2'b11, 1'b0, 0);
            if (i == 0) first_pkg = q_if.in_pkg_i;
            step();
        end
        check("three_count", count_o, 3'd3);
        drive(0, 2'b00, 1'b0, 0);
        repeat (2) begin
            step();
            check("hold_p1", q_if.pkg_o, first_pkg);
        end
        drive(0, 2'b00, 1'b0, 1);
        repeat (3) step();
        check("drained_valid", q_if.pkg_valid_o, 1'b0);

        // Fill to full, pop one, then wrap the pointers.
        for (int i = 0; i < 4; i++) begin
            drive(1, 2'($urandom_range(1, 3)), 1'b0, 0);
            step();
        end
        check("full_in_ready", q_if.in_ready_o, 1'b0);
        check("full_count", count_o, 3'd4);
        drive(0, 2'b00, 1'b0, 1);
        step();
        check("after_pop_ready", q_if.in_ready_o, 1'b1);
        for (int i = 0; i < 8; i++) begin
            drive(1, 2'($urandom_range(1, 3)), 1'b0, 1);
            step();
        end
        drive(0, 2'b00, 1'b0, 1);
        repeat (6) step();

        // Continuous push and pop: occupancy settles at one.
        for (int i = 0; i < 20; i++) begin
            drive(1, 2'b11, 1'b0, 1);
            step();
            check("stream_count", count_o, 3'd1);
        end
        drive(0, 2'b00, 1'b0, 1);
        step();

        // Redirect with a simultaneous push.
        for (int i = 0; i < 3; i++) begin
            drive(1, 2'b11, 1'b0, 0);
            step();
        end
        drive(1, 2'b11, 1'b0, 1, 1'b1, 1'b1);
        step();
        check("redir_count", count_o, 3'd0);
        check("redir_valid", q_if.pkg_valid_o, 1'b0);

        // Stale packet dropped, fresh packet kept, empty-mask packet consumed silently.
        drive(1, 2'b11, 1'b0, 0);
        step();
        drive(1, 2'b01, 1'b1, 0);
        step();
        check("stale_drop", drop_cnt_o, 16'd1);
        check("stale_count", count_o, 3'd1);
        check("fresh_tid", q_if.pkg_o[0].bpu_predict.tid, 1'b1);
        drive(1, 2'b00, 1'b1, 0);
        step();
        check("empty_mask_drop", drop_cnt_o, 16'd1);
        check("empty_mask_count", count_o, 3'd1);

        // Mid-operation reset with two entries.
        drive(1, 2'b10, 1'b1, 0);
        step();
        check("pre_rst_count", count_o, 3'd2);
        do_reset();

        // Random traffic with occasional redirects and stale packets.
        for (int i = 0; i < 3000; i++) begin
            tid = ($urandom_range(0, 7) == 0) ? ~m_tid : m_tid;
            drive(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), tid,
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 29) == 0),
                  1'($urandom_range(0, 1)));
            step();
        end
        drive(0, 2'b00, 1'b0, 1);
        repeat (6) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
